// File: rtl/bus_pkg.sv
// bus_pkg: shared constants and types for the two-master bus arbiter.
//   BUS_W     - address/data bus width
//   OWN_*     - owner encoding (0 none, 1 master 1, 2 master 2)
//   arb_state_e - arbiter FSM states; encoding equals the owner code
package bus_pkg;

  localparam int unsigned BUS_W = 32;
  localparam int unsigned OWN_W = 2;

  localparam logic [OWN_W-1:0] OWN_NONE = 2'd0;
  localparam logic [OWN_W-1:0] OWN_M1   = 2'd1;
  localparam logic [OWN_W-1:0] OWN_M2   = 2'd2;

  typedef enum logic [OWN_W-1:0] {
    ST_IDLE   = 2'd0,
    ST_OWN_M1 = 2'd1,
    ST_OWN_M2 = 2'd2
  } arb_state_e;

endpackage

// File: rtl/bus_arbiter_if.sv
// bus_arbiter_if: master-side and bus-side signals of the two-master arbiter.
//   slave  modport - seen by the arbiter (master requests/data in, bus out)
//   master modport - seen by whatever drives the masters and the bus port
interface bus_arbiter_if;
  import bus_pkg::*;

  // Master 1
  logic             HBUSREQ_M1_i;
  logic             HLOCK_M1_i;
  logic [BUS_W-1:0] HADDR_M1_bi;
  logic [BUS_W-1:0] HWDATA_M1_bi;
  logic             HWRITE_M1_i;
  logic [BUS_W-1:0] HRDATA_M1_bo;
  logic             HGRANT_M1_o;
  // Master 2
  logic             HBUSREQ_M2_i;
  logic             HLOCK_M2_i;
  logic [BUS_W-1:0] HADDR_M2_bi;
  logic [BUS_W-1:0] HWDATA_M2_bi;
  logic             HWRITE_M2_i;
  logic [BUS_W-1:0] HRDATA_M2_bo;
  logic             HGRANT_M2_o;
  // Shared bus master port
  logic [OWN_W-1:0] HMASTER_o;
  logic [BUS_W-1:0] HADDR_bo;
  logic [BUS_W-1:0] HWDATA_bo;
  logic             HWRITE_o;
  logic [BUS_W-1:0] HRDATA_bi;

  modport slave (
    input  HBUSREQ_M1_i, HLOCK_M1_i, HADDR_M1_bi, HWDATA_M1_bi, HWRITE_M1_i,
    input  HBUSREQ_M2_i, HLOCK_M2_i, HADDR_M2_bi, HWDATA_M2_bi, HWRITE_M2_i,
    input  HRDATA_bi,
    output HRDATA_M1_bo, HGRANT_M1_o, HRDATA_M2_bo, HGRANT_M2_o,
    output HMASTER_o, HADDR_bo, HWDATA_bo, HWRITE_o
  );

  modport master (
    output HBUSREQ_M1_i, HLOCK_M1_i, HADDR_M1_bi, HWDATA_M1_bi, HWRITE_M1_i,
    output HBUSREQ_M2_i, HLOCK_M2_i, HADDR_M2_bi, HWDATA_M2_bi, HWRITE_M2_i,
    output HRDATA_bi,
    input  HRDATA_M1_bo, HGRANT_M1_o, HRDATA_M2_bo, HGRANT_M2_o,
    input  HMASTER_o, HADDR_bo, HWDATA_bo, HWRITE_o
  );

endinterface

// File: rtl/arb_fsm.sv
// arb_fsm: round-robin ownership FSM with hold limit for two bus masters.
//   clk_i, rst_i          - clock, async active-high reset
//   req_m1_i, req_m2_i    - bus requests
//   lock_m1_i, lock_m2_i  - locked-transfer requests (honoured only with ARB_LOCK_EN)
//   owner_o               - address-phase owner (equals state encoding)
//   grant_m1_o/grant_m2_o - registered one-hot grants
// Macro ARB_LOCK_EN: when defined, the owner's lock suppresses hold-limit preemption.
module arb_fsm
  import bus_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_m1_i,
  input  logic             req_m2_i,
  input  logic             lock_m1_i,
  input  logic             lock_m2_i,
  output logic [OWN_W-1:0] owner_o,
  output logic             grant_m1_o,
  output logic             grant_m2_o
);

  localparam int unsigned HW = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  arb_state_e    state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          last_m2_q, last_m2_d;   // last owner was M2; reset value favours M1
  logic          grant_m1_q, grant_m2_q;

  logic          own_req, oth_req, own_lock, locked;
  arb_state_e    other_st;

  // Owner-relative view of the requests so both OWN states share one rule set
  always_comb begin
    own_req  = 1'b0;
    oth_req  = 1'b0;
    own_lock = 1'b0;
    other_st = ST_IDLE;
    case (state_q)
      ST_OWN_M1: begin
        own_req  = req_m1_i;
        oth_req  = req_m2_i;
        own_lock = lock_m1_i;
        other_st = ST_OWN_M2;
      end
      ST_OWN_M2: begin
        own_req  = req_m2_i;
        oth_req  = req_m1_i;
        own_lock = lock_m2_i;
        other_st = ST_OWN_M1;
      end
      default: ;
    endcase
  end

`ifdef ARB_LOCK_EN
  assign locked = own_lock;
`else
  logic unused_lock;
  assign unused_lock = own_lock;
  assign locked      = 1'b0;
`endif

  // Next-state, hold counter and priority pointer
  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    last_m2_d = last_m2_q;

    if (state_q == ST_IDLE) begin
      if (req_m1_i && req_m2_i) state_d = last_m2_q ? ST_OWN_M1 : ST_OWN_M2;
      else if (req_m1_i)        state_d = ST_OWN_M1;
      else if (req_m2_i)        state_d = ST_OWN_M2;
    end else begin
      // An undecodable state has own_req=oth_req=0 and falls back to IDLE
      if (!own_req && oth_req)                             state_d = other_st;
      else if (!own_req)                                   state_d = ST_IDLE;
      else if (oth_req && (hold_q == HOLD_LAST) && !locked) state_d = other_st;
      else if (hold_q != HOLD_LAST)                        hold_d  = hold_q + HW'(1);
    end

    if (state_d != state_q) hold_d = '0;

    if (state_d == ST_OWN_M1)      last_m2_d = 1'b0;
    else if (state_d == ST_OWN_M2) last_m2_d = 1'b1;
  end

  // State register and registered grant decodes
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      hold_q     <= '0;
      last_m2_q  <= 1'b1;
      grant_m1_q <= 1'b0;
      grant_m2_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      last_m2_q  <= last_m2_d;
      grant_m1_q <= (state_d == ST_OWN_M1);
      grant_m2_q <= (state_d == ST_OWN_M2);
    end
  end

  assign owner_o    = state_q;
  assign grant_m1_o = grant_m1_q;
  assign grant_m2_o = grant_m2_q;

endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master arbiter and master-side bus multiplexer.
//   HCLK_i   - bus clock
//   HRESET_i - async active-high reset
//   bus      - bus_arbiter_if.slave: master requests/locks/addr/wdata/write,
//              per-master rdata and grants, shared HMASTER/HADDR/HWDATA/HWRITE,
//              HRDATA from the bus
// Macro ARB_LOCK_EN: enables HLOCK_Mx_i suppression of hold-limit preemption.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 4
) (
  input logic          HCLK_i,
  input logic          HRESET_i,
  bus_arbiter_if.slave bus
);

  logic [OWN_W-1:0] owner;
  logic             grant_m1, grant_m2;
  logic [OWN_W-1:0] downer_q, downer_d;

  logic [BUS_W-1:0] haddr, hwdata, hrdata_m1, hrdata_m2;
  logic             hwrite;

  arb_fsm #(
    .MAX_HOLD (MAX_HOLD)
  ) u_arb_fsm (
    .clk_i      (HCLK_i),
    .rst_i      (HRESET_i),
    .req_m1_i   (bus.HBUSREQ_M1_i),
    .req_m2_i   (bus.HBUSREQ_M2_i),
    .lock_m1_i  (bus.HLOCK_M1_i),
    .lock_m2_i  (bus.HLOCK_M2_i),
    .owner_o    (owner),
    .grant_m1_o (grant_m1),
    .grant_m2_o (grant_m2)
  );

  // Data-phase owner trails the address-phase owner by one cycle
  assign downer_d = owner;

  always_ff @(posedge HCLK_i or posedge HRESET_i) begin
    if (HRESET_i) downer_q <= OWN_NONE;
    else          downer_q <= downer_d;
  end

  // Address/control from the address-phase owner
  always_comb begin
    haddr  = '0;
    hwrite = 1'b0;
    case (owner)
      OWN_M1: begin
        haddr  = bus.HADDR_M1_bi;
        hwrite = bus.HWRITE_M1_i;
      end
      OWN_M2: begin
        haddr  = bus.HADDR_M2_bi;
        hwrite = bus.HWRITE_M2_i;
      end
      default: ;
    endcase
  end

  // Write data and read-data return follow the data-phase owner
  always_comb begin
    hwdata    = '0;
    hrdata_m1 = '0;
    hrdata_m2 = '0;
    case (downer_q)
      OWN_M1: begin
        hwdata    = bus.HWDATA_M1_bi;
        hrdata_m1 = bus.HRDATA_bi;
      end
      OWN_M2: begin
        hwdata    = bus.HWDATA_M2_bi;
        hrdata_m2 = bus.HRDATA_bi;
      end
      default: ;
    endcase
  end

  assign bus.HMASTER_o    = owner;
  assign bus.HGRANT_M1_o  = grant_m1;
  assign bus.HGRANT_M2_o  = grant_m2;
  assign bus.HADDR_bo     = haddr;
  assign bus.HWRITE_o     = hwrite;
  assign bus.HWDATA_bo    = hwdata;
  assign bus.HRDATA_M1_bo = hrdata_m1;
  assign bus.HRDATA_M2_bo = hrdata_m2;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed, table-driven check of bus_arbiter with MAX_HOLD = 4.
// Build with +define+ARB_LOCK_EN to exercise the locked-transfer variant.
module tb_bus_arbiter;

  localparam logic [31:0] ADDR1  = 32'h0000_0010;
  localparam logic [31:0] ADDR2  = 32'h0000_0020;
  localparam logic [31:0] WDATA1 = 32'hDEAD_BEEF;
  localparam logic [31:0] WDATA2 = 32'hCAFE_0002;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  bus_arbiter_if bif ();

  bus_arbiter #(
    .MAX_HOLD (4)
  ) dut (
    .HCLK_i   (clk),
    .HRESET_i (rst),
    .bus      (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        r1;
    logic        r2;
    logic [31:0] rdata;
    logic [1:0]  m;     // expected address-phase owner after the edge
    logic [1:0]  d;     // expected data-phase owner after the edge
  } vec_t;

  vec_t vecs [21];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  // Full output check given expected owner m, data owner d and the applied HRDATA
  task automatic check_all(input string tag, input logic [1:0] m, input logic [1:0] d,
                           input logic [31:0] rdata);
    logic [31:0] e_addr, e_wdata, e_rd1, e_rd2;
    logic        e_write;
    e_addr  = (m == 2'd1) ? ADDR1 : (m == 2'd2) ? ADDR2 : 32'h0;
    e_write = (m == 2'd1);
    e_wdata = (d == 2'd1) ? WDATA1 : (d == 2'd2) ? WDATA2 : 32'h0;
    e_rd1   = (d == 2'd1) ? rdata : 32'h0;
    e_rd2   = (d == 2'd2) ? rdata : 32'h0;
    chk({tag, " hmaster"}, 32'(bif.HMASTER_o), 32'(m));
    chk({tag, " grant1"}, 32'(bif.HGRANT_M1_o), 32'(m == 2'd1));
    chk({tag, " grant2"}, 32'(bif.HGRANT_M2_o), 32'(m == 2'd2));
    chk({tag, " haddr"}, bif.HADDR_bo, e_addr);
    chk({tag, " hwrite"}, 32'(bif.HWRITE_o), 32'(e_write));
    chk({tag, " hwdata"}, bif.HWDATA_bo, e_wdata);
    chk({tag, " hrdata1"}, bif.HRDATA_M1_bo, e_rd1);
    chk({tag, " hrdata2"}, bif.HRDATA_M2_bo, e_rd2);
  endtask

  // Drive inputs mid-cycle, then sample just after the next rising edge
  task automatic apply(input logic r1, input logic r2, input logic l1, input logic l2,
                       input logic [31:0] rdata);
    @(negedge clk);
    bif.HBUSREQ_M1_i = r1;
    bif.HBUSREQ_M2_i = r2;
    bif.HLOCK_M1_i   = l1;
    bif.HLOCK_M2_i   = l2;
    bif.HRDATA_bi    = rdata;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] e_m;
    n_tests = 0;
    n_fail  = 0;

    rst              = 1'b1;
    bif.HBUSREQ_M1_i = 1'b0;
    bif.HBUSREQ_M2_i = 1'b0;
    bif.HLOCK_M1_i   = 1'b0;
    bif.HLOCK_M2_i   = 1'b0;
    bif.HADDR_M1_bi  = ADDR1;
    bif.HADDR_M2_bi  = ADDR2;
    bif.HWDATA_M1_bi = WDATA1;
    bif.HWDATA_M2_bi = WDATA2;
    bif.HWRITE_M1_i  = 1'b1;
    bif.HWRITE_M2_i  = 1'b0;
    bif.HRDATA_bi    = 32'h1111_1111;

    // Vector table: idle, single master, release handover, idle, contention
    vecs[0]  = '{1'b0, 1'b0, 32'h0000_0055, 2'd0, 2'd0};
    vecs[1]  = '{1'b1, 1'b0, 32'h0000_0066, 2'd1, 2'd0};
    vecs[2]  = '{1'b1, 1'b0, 32'h0000_0077, 2'd1, 2'd1};
    vecs[3]  = '{1'b0, 1'b1, 32'h0000_1234, 2'd2, 2'd1};
    vecs[4]  = '{1'b0, 1'b1, 32'h0000_00AB, 2'd2, 2'd2};
    vecs[5]  = '{1'b0, 1'b0, 32'h0000_00CD, 2'd0, 2'd2};
    vecs[6]  = '{1'b0, 1'b0, 32'hFFFF_FFFF, 2'd0, 2'd0};
    vecs[7]  = '{1'b1, 1'b1, 32'h0000_0007, 2'd1, 2'd0};
    vecs[8]  = '{1'b1, 1'b1, 32'h0000_0008, 2'd1, 2'd1};
    vecs[9]  = '{1'b1, 1'b1, 32'h0000_0009, 2'd1, 2'd1};
    vecs[10] = '{1'b1, 1'b1, 32'h0000_000A, 2'd1, 2'd1};
    vecs[11] = '{1'b1, 1'b1, 32'h0000_000B, 2'd2, 2'd1};
    vecs[12] = '{1'b1, 1'b1, 32'h0000_000C, 2'd2, 2'd2};
    vecs[13] = '{1'b1, 1'b1, 32'h0000_000D, 2'd2, 2'd2};
    vecs[14] = '{1'b1, 1'b1, 32'h0000_000E, 2'd2, 2'd2};
    vecs[15] = '{1'b1, 1'b1, 32'h0000_000F, 2'd1, 2'd2};
    vecs[16] = '{1'b1, 1'b1, 32'h0000_0010, 2'd1, 2'd1};
    vecs[17] = '{1'b1, 1'b1, 32'h0000_0011, 2'd1, 2'd1};
    vecs[18] = '{1'b1, 1'b1, 32'h0000_0012, 2'd1, 2'd1};
    vecs[19] = '{1'b0, 1'b0, 32'h0000_0013, 2'd0, 2'd1};
    vecs[20] = '{1'b0, 1'b0, 32'hA5A5_A5A5, 2'd0, 2'd0};

    // Power-on reset
    repeat (2) @(posedge clk);
    #1;
    check_all("por", 2'd0, 2'd0, 32'h1111_1111);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 21; i++) begin
      apply(vecs[i].r1, vecs[i].r2, 1'b0, 1'b0, vecs[i].rdata);
      check_all($sformatf("vec%0d", i), vecs[i].m, vecs[i].d, vecs[i].rdata);
    end

    // Lock: M1 requests alone, then M2 joins; M1 lock sampled high at the
    // edges ending owned cycles 1..9 and low from cycle 10 on
    apply(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    chk("lock cyc1 hmaster", 32'(bif.HMASTER_o), 32'd1);
    for (int k = 2; k <= 11; k++) begin
      apply(1'b1, 1'b1, (k <= 10), 1'b0, 32'h0);
`ifdef ARB_LOCK_EN
      e_m = (k <= 10) ? 2'd1 : 2'd2;
`else
      e_m = (k <= 4) ? 2'd1 : (k <= 8) ? 2'd2 : 2'd1;
`endif
      chk($sformatf("lock cyc%0d hmaster", k), 32'(bif.HMASTER_o), 32'(e_m));
      chk($sformatf("lock cyc%0d grant2", k), 32'(bif.HGRANT_M2_o), 32'(e_m == 2'd2));
    end
    apply(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("lock release hmaster", 32'(bif.HMASTER_o), 32'd0);

    // Reset mid-transfer while M2 owns with a live data phase
    apply(1'b0, 1'b1, 1'b0, 1'b0, 32'h4242);
    apply(1'b0, 1'b1, 1'b0, 1'b0, 32'h4242);
    check_all("pre_reset", 2'd2, 2'd2, 32'h4242);
    @(negedge clk);
    rst              = 1'b1;
    bif.HBUSREQ_M1_i = 1'b1;
    bif.HBUSREQ_M2_i = 1'b1;
    #1;
    check_all("mid_reset", 2'd0, 2'd0, 32'h4242);
    @(posedge clk);
    #1;
    check_all("held_reset", 2'd0, 2'd0, 32'h4242);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_all("post_reset_tie", 2'd1, 2'd0, 32'h4242);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Two-master arbiter and master-side multiplexer placed between two bus masters and the master port of the `bus` address decoder. It arbitrates bus requests round-robin, limits how long one master may hold the bus while the other waits, and drives the winner's address/control onto the shared bus. Read data is returned to the master that owns the current data phase.

## Interface
- `MAX_HOLD`, 4: maximum consecutive owned cycles while the other master is requesting; legal range 1..255.
- `HCLK_i`  in  1  bus clock; all state changes on the rising edge.
- `HRESET_i`  in  1  asynchronous, active-high reset.
- `HBUSREQ_M1_i`, `HBUSREQ_M2_i`  in  1  bus request from master 1 / master 2.
- `HLOCK_M1_i`, `HLOCK_M2_i`  in  1  locked-transfer request; only used when `ARB_LOCK_EN` is defined.
- `HADDR_M1_bi`, `HADDR_M2_bi`  in  32  master address.
- `HWDATA_M1_bi`, `HWDATA_M2_bi`  in  32  master write data.
- `HWRITE_M1_i`, `HWRITE_M2_i`  in  1  master write strobe.
- `HRDATA_M1_bo`, `HRDATA_M2_bo`  out  32  read data returned to each master.
- `HGRANT_M1_o`, `HGRANT_M2_o`  out  1  registered grant.
- `HMASTER_o`  out  2  address-phase owner: 0 none, 1 M1, 2 M2.
- `HADDR_bo`, `HWDATA_bo`  out  32  to the bus master port.
- `HWRITE_o`  out  1  to the bus master port.
- `HRDATA_bi`  in  32  from the bus master port.

## Operation
- FSM states: IDLE, OWN_M1, OWN_M2. Grants are one-hot registered decodes of the state. `HMASTER_o` equals the state encoding.
- A priority pointer records the last owner. After reset it favours M1. A tie is resolved in favour of the master that is not the last owner.
- IDLE: no request stays in IDLE. Any request moves to OWN_Mx for the winner.
- OWN_Mx, evaluated each cycle in this order:
  - Own request low and other request high: switch to the other master.
  - Own request low and other request low: go to IDLE.
  - Other request high, `hold_cnt == MAX_HOLD-1`, and not locked: switch (preemption).
  - Otherwise stay and increment `hold_cnt`.
- `hold_cnt` is $clog2(MAX_HOLD+1) bits wide. It clears on every state change and saturates at MAX_HOLD-1 while no other request is pending.
- Address mux: `HADDR_bo` and `HWRITE_o` come combinationally from the address-phase owner. In IDLE both are 0.
- Data-phase owner is the address-phase owner delayed one cycle (register `downer`).
  - `HWDATA_bo` is taken from `downer`'s master.
  - `HRDATA_bi` is routed to `downer`'s master; the other master's `HRDATA_*_bo` is 0.
  - When `downer` = none, `HWDATA_bo` = 0 and both `HRDATA_*_bo` = 0.
- Reset values: state IDLE, `downer` none, pointer favours M1, `hold_cnt` 0. All outputs are 0.
- Reset asserted mid-transfer clears all state immediately. Any in-flight data phase is dropped with no completion cycle.

## Timing
- Request-to-grant latency: a request sampled at edge N produces a grant visible after edge N; the first owned address phase is cycle N+1.
- Handover is zero-bubble. The old owner's last address cycle is followed directly by the new owner's first address cycle, while the old owner's data phase overlaps it via `downer`.
- Release latency: a request dropped at edge N removes the grant after edge N. `HRDATA` for the final address phase is still routed to that master in the following cycle.
- Simultaneous first requests from both masters while in IDLE go to the pointer winner. The loser is granted at the latest MAX_HOLD cycles later.

## Configuration
- `ARB_LOCK_EN` defined: while the owner holds `HLOCK_Mx_i` high, preemption by `MAX_HOLD` is suppressed; a voluntary release still switches. The lock is sampled each cycle.
- `ARB_LOCK_EN` undefined: the `HLOCK_*` ports exist but are ignored, and preemption always applies.

## Structure
- `bus_pkg` holds:
  - owner encoding constants `OWN_NONE` = 0, `OWN_M1` = 1, `OWN_M2` = 2;
  - the arbiter state enum;
  - the 32-bit bus width constant.
- Sub-module `arb_fsm`: state register, priority pointer and `hold_cnt`. It outputs the address owner and grants.
- `bus_arbiter` instantiates `arb_fsm` and contains the `downer` register and the three muxes.

## Test plan
All scenarios use `MAX_HOLD` = 4.

- **Reset:** assert `HRESET_i` mid-transfer while owner = M2 → all outputs are 0 in the same cycle; after release, an M1/M2 tie is granted to M1.
- **Single master:** M1 requests, address 0x0000_0010, write 0xDEAD_BEEF → `HGRANT_M1_o` is 1 one edge later; `HADDR_bo` = 0x10 in the owned cycle and `HWDATA_bo` = 0xDEAD_BEEF in the next.
- **Contention:** both masters request continuously → ownership alternates M1×4, M2×4, M1×4 with no idle cycles.
- **Release:** M1 owns, drops its request while M2 requests in the same cycle → M2 is granted on the next edge; `HRDATA_bi` = 0x1234 in that cycle goes to `HRDATA_M1_bo`, and `HRDATA_M2_bo` = 0.
- **Lock (`ARB_LOCK_EN` defined):** M1 holds its lock for 10 cycles with M2 requesting → M1 keeps ownership for all 10 cycles, then M2 is granted. With the macro undefined → M2 is granted after 4 cycles.
- **Idle:** no requests → `HMASTER_o` = 0, `HADDR_bo` = 0, and both `HRDATA_*_bo` = 0 regardless of `HRDATA_bi`.
